seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, clocked successor to the combinational calculator datapath.
- Performs add, sub, signed multiply, signed divide and signed modulo on two WIDTH-bit two's-complement operands.
- Result is 2*WIDTH bits wide, returned through a start/busy/done handshake.
- Multiply and divide/modulo are iterative (one bit per clock), replacing the unbounded combinational loops; sits between the operand/opcode source and the result display/register stage.

Parameters:
- WIDTH, 16, operand width in bits (legal range 4..32); result width is 2*WIDTH.
- CW, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request pulse; sampled only in IDLE.
- op_code  in  4  0=add, 1=sub, 2=mul, 3=div, 4=mod, 5..15 invalid.
- input1  in  WIDTH  operand A, signed.
- input2  in  WIDTH  operand B, signed.
- busy  out  1  high in CALC and DONE states.
- done  out  1  one-cycle pulse; output1/err_code valid from this cycle onward.
- output1  out  2*WIDTH  signed result, held until the next accepted start.
- err_code  out  2  bit1 = divide/modulo by zero; bit0 = invalid opcode.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; output1=0; err_code=0; counter and shift registers cleared. Reset mid-operation aborts with no done pulse.
- Capture edge E0 is the first rising edge with state=IDLE and start=1. At E0, op_code/input1/input2 are registered; later input changes have no effect.
- States: IDLE, CALC, DONE.
- IDLE -> DONE at E0 for the fast ops:
  - add: sext(A)+sext(B).
  - sub: sext(A)-sext(B).
  - invalid opcode: output1=0, err_code=01.
  - div/mod with B==0: output1=0, err_code=10.
  - Fast-op latency is 1: done=1 in the cycle after E0.
- IDLE -> CALC at E0 for mul/div/mod with valid operands:
  - Magnitudes |A|,|B| are latched (2*WIDTH-internal, so the most-negative value is handled) with result-sign flags; counter=WIDTH.
- CALC: one iteration per edge.
  - mul: shift-add over |B| bits.
  - div/mod: restoring shift-subtract.
  - Counter decrements. When the counter reaches 0 on edge E0+WIDTH, state stays CALC one more edge for sign correction.
  - At E0+WIDTH+1: registered output1 = sign-corrected result, err_code=00, state -> DONE.
  - Latency WIDTH+1 cycles (17 at WIDTH=16).
- DONE: done=1 for exactly one cycle, busy=1; unconditionally -> IDLE next edge. start asserted during DONE is ignored.
- start while busy=1 is ignored, not queued.
- Arithmetic rules:
  - Results are sign-extended to 2*WIDTH.
  - Division truncates toward zero.
  - Remainder takes the sign of the dividend (A = q*B + r).
  - Most-negative/-1 yields +2^(WIDTH-1); no overflow, since the result is 2*WIDTH wide.
  - Multiply is exact in 2*WIDTH bits.
- err_code clears to 00 on every successful operation; output1/err_code update only on the transition into DONE.
- done and busy are never both low while a CALC iteration is in progress.

Test Plan:
- Add, WIDTH=16, A=11, B=15, op 0 -> done 1 cycle after E0, output1=26, err=00. Sub, same operands, op 1 -> output1=-4 (0xFFFFFFFC).
- Mul, A=32000, B=16000, op 2 -> done exactly 17 cycles after E0, output1=512000000, err=00. Mul, A=-3, B=7 -> -21.
- Div/mod signs: A=-7, B=2 -> div -3, mod -1. A=7, B=-2 -> div -3, mod 1. A=-32768, B=-1, op 3 -> output1=32768.
- Error cases: A=11, B=0, op 3 and op 4 -> done after 1 cycle, output1=0, err=10. op 9 -> output1=0, err=01. A following valid add -> err=00.
- Handshake: start held high continuously with op 2 -> start during CALC/DONE ignored, a new capture only in IDLE. done pulses are 19 cycles apart (E0 edge, 16 iterations + fixup, DONE, IDLE); input changes during CALC do not alter the result.
- Reset mid-mul (after 5 CALC cycles) -> busy/done/output1/err immediately 0, no done pulse. A subsequent 11*15 gives 165 with full 17-cycle latency.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: clocked signed ALU with a start/busy/done handshake.
//   add and sub finish in one cycle. Multiply, divide and modulo iterate one
//   bit per clock and then spend one more clock on sign correction.
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   start                request, sampled only in IDLE
//   op_code              0=add 1=sub 2=mul 3=div 4=mod, others invalid
//   input1, input2       signed WIDTH-bit operands
//   busy, done           busy in CALC/DONE, done is a one-cycle pulse in DONE
//   output1              signed 2*WIDTH result, held until the next accepted start
//   err_code             bit1 divide/modulo by zero, bit0 invalid opcode
//
// state  | meaning
// S_IDLE | waiting for start, operands captured on the accepting edge
// S_CALC | one shift-add / shift-subtract step per edge, then sign fixup
// S_DONE | result valid, done pulse, always returns to S_IDLE
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         op_code,
  input  logic [WIDTH-1:0]   input1,
  input  logic [WIDTH-1:0]   input2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] output1,
  output logic [1:0]         err_code
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int RW = 2 * WIDTH;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_MOD = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [3:0]    op_r;
  logic [CW-1:0] cnt;
  logic [RW-1:0] mag_a;
  logic [RW-1:0] mag_b;
  logic [RW-1:0] acc;
  logic          neg_r;

  logic [RW-1:0] a_ext, b_ext, a_abs, b_abs;
  logic [RW-1:0] fast_res;
  logic [1:0]    fast_err;
  logic          is_slow;
  logic          neg_new;
  logic [RW-1:0] trial, q_ext, base, final_res;
  logic          ge;

  // Operand decode for the accepting edge. Magnitudes are taken at 2*WIDTH
  // so the most-negative operand has a representable absolute value.
  always_comb begin
    a_ext    = {{WIDTH{input1[WIDTH-1]}}, input1};
    b_ext    = {{WIDTH{input2[WIDTH-1]}}, input2};
    a_abs    = input1[WIDTH-1] ? (~a_ext + 1'b1) : a_ext;
    b_abs    = input2[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;
    is_slow  = (op_code == OP_MUL) ||
               (((op_code == OP_DIV) || (op_code == OP_MOD)) && (input2 != '0));
    // Remainder follows the dividend; product and quotient follow sign xor.
    neg_new  = (op_code == OP_MOD) ? input1[WIDTH-1]
                                   : (input1[WIDTH-1] ^ input2[WIDTH-1]);
    fast_res = '0;
    fast_err = 2'b00;
    case (op_code)
      OP_ADD:                 fast_res = a_ext + b_ext;
      OP_SUB:                 fast_res = a_ext - b_ext;
      OP_MUL, OP_DIV, OP_MOD: fast_err = 2'b10;  // only reachable as x/0
      default:                fast_err = 2'b01;
    endcase
  end

  // Restoring division: the dividend bits stream out of mag_a MSB first and
  // quotient bits stream into its bottom, so after WIDTH steps the low half
  // of mag_a is the quotient and acc is the remainder.
  always_comb begin
    trial     = {acc[RW-2:0], mag_a[WIDTH-1]};
    ge        = (trial >= mag_b);
    q_ext     = {{WIDTH{1'b0}}, mag_a[WIDTH-1:0]};
    base      = (op_r == OP_DIV) ? q_ext : acc;
    final_res = neg_r ? (~base + 1'b1) : base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = is_slow ? S_CALC : S_DONE;
      end
      S_CALC: begin
        busy = 1'b1;
        if (cnt == '0) next_state = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= '0;
      cnt      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      neg_r    <= 1'b0;
      output1  <= '0;
      err_code <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r <= op_code;
            if (is_slow) begin
              mag_a <= a_abs;
              mag_b <= b_abs;
              acc   <= '0;
              neg_r <= neg_new;
              cnt   <= CW'(WIDTH);
            end else begin
              output1  <= fast_res;
              err_code <= fast_err;
            end
          end
        end
        S_CALC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (op_r == OP_MUL) begin
              if (mag_b[0]) acc <= acc + mag_a;
              mag_a <= {mag_a[RW-2:0], 1'b0};
              mag_b <= {1'b0, mag_b[RW-1:1]};
            end else begin
              acc   <= ge ? (trial - mag_b) : trial;
              mag_a <= {mag_a[RW-2:0], ge};
            end
          end else begin
            // Extra edge after the last iteration applies the sign.
            output1  <= final_res;
            err_code <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
